// File: rtl/ti_q_stage_pkg.sv
// Shared definitions for the 3-share threshold-implemented Midori64 S-box datapath.
package ti_q_stage_pkg;
   localparam int SHARE_W = 4;
   localparam int NSHARES = 3;

   typedef logic [SHARE_W-1:0] share_t;

   // One buffered result: the three output shares plus the end-of-state tag.
   // y[0] is output share 1, y[1] share 2, y[2] share 3.
   typedef struct packed {
      share_t [NSHARES-1:0] y;
      logic                 last;
   } q_entry_t;
endpackage

// File: rtl/ti_q_share.sv
// One output share of the quadratic layer Q(a,b,c,d) = (a, b, c^ab, d^ac).
// Sees exactly two input shares, so non-completeness holds by construction:
// lin_s supplies the linear bits, oth_s only enters the cross products.
module ti_q_share
   import ti_q_stage_pkg::*;
(
   input  logic [SHARE_W-1:0] lin_s,
   input  logic [SHARE_W-1:0] oth_s,
   output logic [SHARE_W-1:0] y_s
);

   logic ab_t;
   logic ac_t;

   // Shared products a*b and a*c followed by the linear pass-through of a, b, c, d.
   always_comb begin
      ab_t = (lin_s[3] & lin_s[2]) ^ (lin_s[3] & oth_s[2]) ^ (oth_s[3] & lin_s[2]);
      ac_t = (lin_s[3] & lin_s[1]) ^ (lin_s[3] & oth_s[1]) ^ (oth_s[3] & lin_s[1]);
      y_s  = {lin_s[3], lin_s[2], lin_s[1] ^ ab_t, lin_s[0] ^ ac_t};
   end

endmodule

// File: rtl/ti_q_stage.sv
// Registered quadratic layer of the 3-share TI Midori64 S-box.
// Main output register plus a one-entry skid buffer: the register is the glitch
// barrier between the shared Q evaluation and the next affine layer, and the
// skid keeps in_ready a pure flop output while sustaining one nibble per cycle.
module ti_q_stage
   import ti_q_stage_pkg::*;
#(
   parameter int NIBBLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SHARE_W-1:0] x1,
   input  logic [SHARE_W-1:0] x2,
   input  logic [SHARE_W-1:0] x3,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SHARE_W-1:0] y1,
   output logic [SHARE_W-1:0] y2,
   output logic [SHARE_W-1:0] y3,
   output logic               out_last
);

   localparam int               IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   share_t           q1;
   share_t           q2;
   share_t           q3;
   q_entry_t         in_entry;
   q_entry_t         main_d;
   q_entry_t         main_q;
   q_entry_t         skid_d;
   q_entry_t         skid_q;
   logic             main_vld_d;
   logic             main_vld_q;
   logic             skid_vld_d;
   logic             skid_vld_q;
   logic [IDX_W-1:0] idx_d;
   logic [IDX_W-1:0] idx_q;
   logic             accept;
   logic             drain;

   // Rotated share wiring: share i never sees input share i.
   ti_q_share u_share1 (.lin_s(x2), .oth_s(x3), .y_s(q1));
   ti_q_share u_share2 (.lin_s(x3), .oth_s(x1), .y_s(q2));
   ti_q_share u_share3 (.lin_s(x1), .oth_s(x2), .y_s(q3));

   assign in_ready  = !skid_vld_q;
   assign accept    = in_valid && in_ready;
   assign drain     = main_vld_q && out_ready;

   assign out_valid = main_vld_q;
   assign y1        = main_q.y[0];
   assign y2        = main_q.y[1];
   assign y3        = main_q.y[2];
   assign out_last  = main_q.last;

   // Candidate entry for the nibble currently offered, tagged when it closes a state.
   always_comb begin
      in_entry.y    = {q3, q2, q1};
      in_entry.last = (idx_q == IDX_LAST);
   end

   // Nibble position within the state, advanced on every accepted input.
   always_comb begin
      idx_d = idx_q;
      if (accept) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Main/skid occupancy: refill main from skid first so order is preserved;
   // park a new nibble in the skid only when main is held by backpressure.
   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!main_vld_q || drain) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            if (accept) begin
               main_d = in_entry;
            end
            main_vld_d = accept;
         end
      end else if (accept) begin
         skid_d     = in_entry;
         skid_vld_d = 1'b1;
      end
   end

   // State registers; reset flushes in-flight nibbles and restarts the state count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         idx_q      <= '0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         idx_q      <= idx_d;
      end
   end

endmodule
